wb_esc_pwm: RTL
===============

// Module: wb_esc_pwm
// PURPOSE
//  4-channel ESC/motor PWM generator; Wishbone slave on conbus slot 0x40000000, drives PWMmotors[3:0].
//  Duty and period updates are glitch-free: shadow registers load only at the period boundary.
//  A watchdog forces all channels to a failsafe pulse when the CPU stops writing duties.
//  An end-of-period interrupt lets firmware pace the control loop.
// PARAMETERS
//  cnt_w      20      width of period counter, PERIOD and DUTY registers (cycles)
//  def_period 250000  PERIOD reset value (2.5 ms at 100 MHz, 400 Hz ESC rate)
//  fail_duty  100000  pulse width in failsafe (1.0 ms = motor stop)
// PORTS
//  clk        in   1   system clock; the only clock
//  rst        in   1   reset, synchronous, active-low
//  wb_adr_i   in   32  byte address; [4:2] select register
//  wb_dat_i   in   32  write data
//  wb_dat_o   out  32  read data
//  wb_sel_i   in   4   byte lanes; ignored, all writes are full-word
//  wb_stb_i   in   1   strobe
//  wb_cyc_i   in   1   cycle
//  wb_we_i    in   1   write enable
//  wb_ack_o   out  1   acknowledge
//  intr       out  1   level interrupt = irq_pend & irq_en
//  PWMmotors  out  4   PWM outputs, active high
// BEHAVIOUR
//  Registers (offset): 0x00 CTRL [3:0] ch_en, [4] irq_en, [5] irq_pend (W1C); 0x04 PERIOD;
//   0x08 WDOG [15:0] timeout in periods, 0 = disabled; 0x0C STATUS [0] failsafe (RO);
//   0x10..0x1C DUTY0..3. Unused bits read 0; writes to RO/undefined offsets ignored.
//  Reset: ch_en=0, irq_en=0, irq_pend=0, PERIOD=def_period, WDOG=0, DUTY*=0, shadows=0,
//   counter=0, failsafe=0; outputs wb_ack_o=0, wb_dat_o=0, intr=0, PWMmotors=0.
//  Wishbone: ack asserted 1 cycle after stb&cyc with ack low; ack held 1 cycle; write committed
//   on the ack cycle; wb_dat_o registered, valid with ack. No wait states beyond that; no bursts.
//  Counter: increments 0..PERIOD_sh-1; "wrap" = cycle where counter==PERIOD_sh-1; next cycle
//   counter=0. PERIOD_sh==0 -> counter held at 0, no wraps, all outputs low.
//  On wrap: PERIOD_sh<=PERIOD, DUTYn_sh<=(failsafe ? fail_duty : DUTYn), irq_pend<=1.
//   Write to DUTY/PERIOD on the wrap cycle itself is NOT captured until the following wrap.
//  Output: PWMmotors[n] registered = ch_en[n] & (counter < DUTYn_sh). DUTYn_sh>=PERIOD_sh -> constant
//   high; DUTYn_sh==0 -> constant low. ch_en change takes effect immediately (next cycle).
//  Watchdog: wd_cnt (16b) clears on any DUTYn write; else increments on each wrap while WDOG!=0.
//   wd_cnt reaching WDOG sets failsafe=1 (same wrap loads fail_duty). Any DUTYn write clears
//   failsafe; real duties load at the next wrap. WDOG written 0 clears failsafe and wd_cnt.
//  Simultaneous: W1C of irq_pend on a wrap cycle -> irq_pend stays 1 (set wins).
//   DUTY write on the wrap where wd_cnt hits WDOG -> write wins, failsafe stays 0.
//  Reset mid-period: all state to reset values in one cycle, outputs low next cycle.
// STRUCTURE
//  Shared include wb_esc_pwm_defs.vh: register offsets, CTRL bit positions, STATUS bit positions.
//  Sub-module esc_pwm_channel (x4): DUTY shadow reg + compare + output flop; inputs counter,
//   wrap, failsafe, duty, en. Top holds Wishbone decode, counter, watchdog, irq.
// TESTING
//  1 Reset: PERIOD reads 250000, all other regs 0, PWMmotors=0, intr=0.
//  2 PERIOD=100, DUTY0=25, CTRL=0x1 -> after next wrap PWM0 high exactly 25 of every 100 cycles.
//  3 DUTY0 25->60 mid-period -> current period keeps 25-cycle pulse, next period 60; no glitch.
//  4 DUTY1=100 and DUTY2=0 with PERIOD=100 -> PWM1 constant high, PWM2 constant low.
//  5 WDOG=3, no DUTY writes -> 3rd wrap sets STATUS[0], pulses = fail_duty; DUTY0 write clears.
//  6 CTRL=0x10, W1C irq_pend on a wrap cycle -> irq_pend/intr remain 1; W1C later -> intr=0.

Source files
------------

// File: rtl/wb_esc_pwm_pkg.sv
// Shared definitions for the 4-channel ESC PWM block: register map, CTRL/STATUS bit positions.
package wb_esc_pwm_pkg;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_PERIOD = 3'd1,
    REG_WDOG   = 3'd2,
    REG_STATUS = 3'd3,
    REG_DUTY0  = 3'd4,
    REG_DUTY1  = 3'd5,
    REG_DUTY2  = 3'd6,
    REG_DUTY3  = 3'd7
  } reg_idx_e;

  localparam int N_CH            = 4;
  localparam int WDOG_W          = 16;
  localparam int CTRL_EN_LSB     = 0;
  localparam int CTRL_IRQ_EN     = 4;
  localparam int CTRL_IRQ_PEND   = 5;
  localparam int STATUS_FAILSAFE = 0;

  // DUTY0..3 occupy the upper half of the word-index space.
  function automatic logic is_duty(input logic [2:0] idx);
    return idx[2];
  endfunction

endpackage

// File: rtl/wb_esc_pwm_channel.sv
// One PWM channel: duty shadow loaded at the period boundary, compare, registered output.
module wb_esc_pwm_channel #(
  parameter int cnt_w     = 20,
  parameter int fail_duty = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [cnt_w-1:0] cnt,
  input  logic             load,
  input  logic             run,
  input  logic             failsafe,
  input  logic             en,
  input  logic [cnt_w-1:0] duty,
  output logic             pwm
);

  localparam logic [cnt_w-1:0] FAIL_V = cnt_w'(fail_duty);

  logic [cnt_w-1:0] duty_sh_q, duty_sh_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    duty_sh_d = duty_sh_q;
    if (load) duty_sh_d = failsafe ? FAIL_V : duty;
    // duty >= period gives constant high, duty == 0 constant low, with no special casing.
    pwm_d = en & run & (cnt < duty_sh_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      duty_sh_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      duty_sh_q <= duty_sh_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/wb_esc_pwm.sv
// Wishbone-controlled 4-channel ESC PWM: register file, period counter, watchdog, irq.
module wb_esc_pwm
  import wb_esc_pwm_pkg::*;
#(
  parameter int cnt_w      = 20,
  parameter int def_period = 250000,
  parameter int fail_duty  = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        intr,
  output logic [3:0]  PWMmotors
);

  localparam logic [cnt_w-1:0] CNT_ONE = cnt_w'(1);

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [N_CH-1:0]   ch_en_q, ch_en_d;
  logic              irq_en_q, irq_en_d, irq_pend_q, irq_pend_d;
  logic [cnt_w-1:0]  period_q, period_d, period_sh_q, period_sh_d, cnt_q, cnt_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d, wd_cnt_q, wd_cnt_d;
  logic              failsafe_q, failsafe_d;
  logic [cnt_w-1:0]  duty_q [N_CH];
  logic [cnt_w-1:0]  duty_d [N_CH];

  logic        req, wr, duty_wr, run, wrap, start, load;
  logic [2:0]  reg_sel;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:cnt_w]};

  // Handshake: a request is stb&cyc while ack is low; ack follows one cycle later for one
  // cycle, read data is registered alongside it, and a write lands on the edge ending ack.
  assign req     = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr      = ack_q & wb_stb_i & wb_cyc_i & wb_we_i;
  assign reg_sel = wb_adr_i[4:2];
  assign duty_wr = wr & is_duty(reg_sel);

  // A zero period shadow idles the counter; enabling any channel primes the shadows.
  assign run   = (period_sh_q != '0);
  assign wrap  = run && (cnt_q == period_sh_q - CNT_ONE);
  assign start = ~run & (|ch_en_q);
  assign load  = wrap | start;

  always_comb begin
    case (reg_sel)
      REG_CTRL:   rdata = {26'd0, irq_pend_q, irq_en_q, ch_en_q};
      REG_PERIOD: rdata = 32'(period_q);
      REG_WDOG:   rdata = {16'd0, wdog_q};
      REG_STATUS: rdata = {31'd0, failsafe_q};
      default:    rdata = 32'(duty_q[reg_sel[1:0]]);
    endcase
  end

  always_comb begin
    ack_d       = req;
    dat_d       = req ? rdata : 32'd0;
    ch_en_d     = ch_en_q;
    irq_en_d    = irq_en_q;
    period_d    = period_q;
    wdog_d      = wdog_q;
    duty_d      = duty_q;
    if (wr) begin
      case (reg_sel)
        REG_CTRL: begin
          ch_en_d  = wb_dat_i[CTRL_EN_LSB +: N_CH];
          irq_en_d = wb_dat_i[CTRL_IRQ_EN];
        end
        REG_PERIOD: period_d = wb_dat_i[cnt_w-1:0];
        REG_WDOG:   wdog_d   = wb_dat_i[WDOG_W-1:0];
        REG_DUTY0, REG_DUTY1, REG_DUTY2, REG_DUTY3: duty_d[reg_sel[1:0]] = wb_dat_i[cnt_w-1:0];
        default: ;
      endcase
    end

    irq_pend_d = irq_pend_q;
    if (wrap) irq_pend_d = 1'b1;
    else if (wr && reg_sel == REG_CTRL && wb_dat_i[CTRL_IRQ_PEND]) irq_pend_d = 1'b0;

    cnt_d       = (!run || wrap) ? '0 : cnt_q + CNT_ONE;
    period_sh_d = load ? period_q : period_sh_q;

    // A duty write outranks the timeout on the same wrap so firmware can always recover.
    wd_cnt_d   = wd_cnt_q;
    failsafe_d = failsafe_q;
    if (duty_wr) begin
      wd_cnt_d   = '0;
      failsafe_d = 1'b0;
    end else if (wr && reg_sel == REG_WDOG && wb_dat_i[WDOG_W-1:0] == '0) begin
      wd_cnt_d   = '0;
      failsafe_d = 1'b0;
    end else if (wrap && wdog_q != '0 && !failsafe_q) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
      if (wd_cnt_d >= wdog_q) failsafe_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      ch_en_q     <= '0;
      irq_en_q    <= 1'b0;
      irq_pend_q  <= 1'b0;
      period_q    <= cnt_w'(def_period);
      wdog_q      <= '0;
      duty_q      <= '{default: '0};
      period_sh_q <= '0;
      cnt_q       <= '0;
      wd_cnt_q    <= '0;
      failsafe_q  <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      ch_en_q     <= ch_en_d;
      irq_en_q    <= irq_en_d;
      irq_pend_q  <= irq_pend_d;
      period_q    <= period_d;
      wdog_q      <= wdog_d;
      duty_q      <= duty_d;
      period_sh_q <= period_sh_d;
      cnt_q       <= cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      failsafe_q  <= failsafe_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    wb_esc_pwm_channel #(.cnt_w(cnt_w), .fail_duty(fail_duty)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cnt      (cnt_q),
      .load     (load),
      .run      (run),
      .failsafe (failsafe_d),
      .en       (ch_en_q[i]),
      .duty     (duty_q[i]),
      .pwm      (PWMmotors[i])
    );
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign intr     = irq_pend_q & irq_en_q;

endmodule
